halton5_sbg_sched: RTL and testbench

- Scheduler that shares one base-5 Halton stochastic bitstream generator among NREQ requesters.
- Each request carries a source value and a stream length. The block arbitrates round-robin, restarts the base-5 digit-reversed sequence at index 0, and emits one comparator bit per cycle with valid/ready flow control.
- Sits between unary compute lanes and a shared SBG, so lanes do not each need their own Halton counter.

---
 rtl/halton5_sbg_sched.sv | 134 +++++++++++++
 tb/tb_halton5_sbg_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/halton5_sbg_sched.sv
// Shared base-5 Halton stochastic bitstream generator with round-robin request scheduling.
// One stream at a time: digit-reversed sequence restarts at 0 per accepted request.
module halton5_sbg_sched #(
  parameter int NREQ     = 2,
  parameter int SEQWIDTH = 7,
  parameter int LENWIDTH = 7,
  parameter int PERIOD   = 125,
  parameter int OWW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*SEQWIDTH-1:0]     req_src,
  input  logic [NREQ*LENWIDTH-1:0]     req_len,
  output logic                         bit_valid,
  input  logic                         bit_ready,
  output logic                         bit_out,
  output logic [OWW-1:0]               bit_owner,
  output logic                         bit_last,
  output logic                         busy
);

  // state  | meaning
  // S_IDLE | waiting for a request, round-robin grant from ptr
  // S_RUN  | emitting bits of the accepted stream
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]          state;
  logic [OWW-1:0]      ptr;
  logic [SEQWIDTH-1:0] src_q;
  logic [LENWIDTH-1:0] len_q;
  logic [LENWIDTH-1:0] cnt;
  logic [2:0]          d0, d1, d2;

  logic                gnt_found;
  logic [OWW-1:0]      gnt_idx;
  logic [SEQWIDTH-1:0] src_in;
  logic [LENWIDTH-1:0] len_in;
  logic [LENWIDTH-1:0] len_eff;
  logic [2:0]          nd0, nd1, nd2;
  logic [SEQWIDTH-1:0] h_next;
  logic [LENWIDTH-1:0] ncnt;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[(int'(ptr) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = OWW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !rst && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign src_in  = req_src[int'(gnt_idx)*SEQWIDTH +: SEQWIDTH];
  assign len_in  = req_len[int'(gnt_idx)*LENWIDTH +: LENWIDTH];
  assign len_eff = (len_in == '0) ? LENWIDTH'(PERIOD) : len_in;

  // d0 is the fastest digit but carries the heaviest weight (digit reversal)
  always_comb begin
    nd0 = (d0 == 3'd4) ? 3'd0 : d0 + 3'd1;
    nd1 = d1;
    nd2 = d2;
    if (d0 == 3'd4) begin
      nd1 = (d1 == 3'd4) ? 3'd0 : d1 + 3'd1;
      if (d1 == 3'd4) nd2 = (d2 == 3'd4) ? 3'd0 : d2 + 3'd1;
    end
  end

  assign h_next = SEQWIDTH'(32'(nd0) * 25 + 32'(nd1) * 5 + 32'(nd2));
  assign ncnt   = cnt + LENWIDTH'(1);
  assign busy   = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      src_q     <= '0;
      len_q     <= '0;
      cnt       <= '0;
      d0        <= '0;
      d1        <= '0;
      d2        <= '0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      bit_last  <= 1'b0;
      bit_owner <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            src_q     <= src_in;
            len_q     <= len_eff;
            cnt       <= '0;
            d0        <= '0;
            d1        <= '0;
            d2        <= '0;
            ptr       <= (gnt_idx == OWW'(NREQ-1)) ? '0 : gnt_idx + OWW'(1);
            state     <= S_RUN;
            bit_valid <= 1'b1;
            bit_out   <= (src_in != '0);
            bit_last  <= (len_eff == LENWIDTH'(1));
            bit_owner <= gnt_idx;
          end
        end
        default: begin
          if (bit_valid && bit_ready) begin
            if (bit_last) begin
              state     <= S_IDLE;
              bit_valid <= 1'b0;
              bit_out   <= 1'b0;
              bit_last  <= 1'b0;
            end else begin
              d0       <= nd0;
              d1       <= nd1;
              d2       <= nd2;
              cnt      <= ncnt;
              bit_out  <= (src_q > h_next);
              bit_last <= (ncnt == len_q - LENWIDTH'(1));
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halton5_sbg_sched.sv
// Directed bench for halton5_sbg_sched: stream contents, round-robin order, backpressure, reset.
module tb_halton5_sbg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [13:0] req_src;
  logic [13:0] req_len;
  logic        bit_valid;
  logic        bit_ready;
  logic        bit_out;
  logic [0:0]  bit_owner;
  logic        bit_last;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] bits;
  int           ones;

  halton5_sbg_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_len(req_len),
    .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bit_out(bit_out), .bit_owner(bit_owner),
    .bit_last(bit_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a single request, check its grant, and let it be accepted.
  task automatic accept(input int idx, input int src, input int len);
    req_src[idx*7 +: 7] = 7'(src);
    req_len[idx*7 +: 7] = 7'(len);
    req_valid[idx] = 1'b1;
    #1;
    chk("grant", 128'(req_ready), 128'(2'b01 << idx));
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    chk("busy_after_accept", 128'(busy), 128'(1));
  endtask

  // Gather one stream; bp selects a 1,0,0 bit_ready pattern.
  task automatic collect(input int own, input int len, input bit bp,
                         output logic [127:0] b, output int n1);
    int  k = 0;
    int  cyc = 0;
    bit  stalled = 1'b0;
    logic held_out = 1'b0;
    b  = '0;
    n1 = 0;
    while (k < len && cyc < 2000) begin
      bit_ready = bp ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (stalled) begin
        chk("hold_valid", 128'(bit_valid), 128'(1));
        chk("hold_out", 128'(bit_out), 128'(held_out));
      end
      stalled = bit_valid && !bit_ready;
      held_out = bit_out;
      if (bit_valid && bit_ready) begin
        b[k] = bit_out;
        if (bit_out) n1++;
        chk("owner", 128'(bit_owner), 128'(own));
        chk("last", 128'(bit_last), 128'(k == len - 1));
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bit_ready = 1'b1;
    chk("stream_len", 128'(k), 128'(len));
    chk("idle_after_last", 128'(bit_valid), 128'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 2'b01;
    req_src = '0;
    req_len = '0;
    bit_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_valid", 128'(bit_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    req_valid = 2'b00;
    #1;

    // short stream: h = 0,25,50,75,100 against src 30
    accept(0, 30, 5);
    collect(0, 5, 1'b0, bits, ones);
    chk("short_bits", bits, 128'b00011);

    // full period: ones count equals min(src,125)
    accept(0, 63, 0);
    collect(0, 125, 1'b0, bits, ones);
    chk("full63_ones", 128'(ones), 128'(63));
    accept(0, 125, 0);
    collect(0, 125, 1'b0, bits, ones);
    chk("full125_ones", 128'(ones), 128'(125));
    accept(0, 0, 0);
    collect(0, 125, 1'b0, bits, ones);
    chk("full0_ones", 128'(ones), 128'(0));

    // backpressure: h = 0,25,50,75,100,5 against src 50 (ptr is 1 here)
    accept(1, 50, 6);
    collect(1, 6, 1'b1, bits, ones);
    chk("bp_bits", bits, 128'b100011);

    // round-robin with both requesters held valid, ptr back at 0
    req_src = {7'd10, 7'd30};
    req_len = {7'd3, 7'd3};
    req_valid = 2'b11;
    #1;
    for (int s = 0; s < 4; s++) begin
      chk("rr_bubble", 128'(bit_valid), 128'(0));
      chk("rr_grant", 128'(req_ready), 128'(2'b01 << (s % 2)));
      @(posedge clk); #1;
      collect(s % 2, 3, 1'b0, bits, ones);
      chk("rr_bits", bits, (s % 2 == 0) ? 128'b011 : 128'b001);
    end
    req_valid = 2'b00;
    #1;

    // latching: changes after accept apply only to the next stream
    accept(1, 100, 4);
    req_src[13:7] = 7'd0;
    req_len[13:7] = 7'd2;
    req_valid[1] = 1'b1;
    collect(1, 4, 1'b0, bits, ones);
    chk("latch_bits1", bits, 128'b1111);
    chk("latch_grant", 128'(req_ready), 128'(2'b10));
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    collect(1, 2, 1'b0, bits, ones);
    chk("latch_bits2", bits, 128'b00);

    // reset during a stream: dropped, ptr and outputs cleared
    accept(0, 30, 10);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_run_last", 128'(bit_last), 128'(0));
      chk("rst_run_ready", 128'(req_ready), 128'(0));
    end
    rst = 1'b0;
    #1;
    chk("post_rst_outs", 128'({bit_valid, bit_out, bit_last, busy, bit_owner}), 128'(0));
    chk("post_rst_ready", 128'(req_ready), 128'(0));
    req_src = {7'd30, 7'd30};
    req_len = {7'd10, 7'd10};
    req_valid = 2'b11;
    #1;
    chk("post_rst_ptr", 128'(req_ready), 128'(2'b01));
    @(posedge clk); #1;
    req_valid = 2'b00;
    // h = 0,25,50,75,100,5,30,55,80,105: three values below 30
    collect(0, 10, 1'b0, bits, ones);
    chk("post_rst_ones", 128'(ones), 128'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
